// File: rtl/comma_insertion_pkg.sv
// rtl/comma_insertion_pkg.sv - shared PHY symbols and comma-insertion FSM state type
package comma_insertion_pkg;

    localparam logic [7:0] K28_5      = 8'hBC;
    localparam logic [7:0] FILLER_SYM = 8'h00;

    typedef enum logic {
        ST_BURST = 1'b0,
        ST_DATA  = 1'b1
    } state_t;

endpackage

// File: rtl/comma_insertion.sv
// rtl/comma_insertion.sv - inserts K28.5 alignment bursts into the MAC symbol stream
module comma_insertion
    import comma_insertion_pkg::*;
#(
    parameter int COMMA_COUNT      = 3,
    parameter int REALIGN_INTERVAL = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] TxData_in,
    input  logic       TxDataK_in,
    input  logic       TxValid_in,
    input  logic       Align_req,
    output logic       TxReady,
    output logic [7:0] Data_out,
    output logic       DataK_out,
    output logic       Comma_active,
    output logic       Burst_done
);

    localparam logic [3:0]  LAST_COMMA = 4'(COMMA_COUNT - 1);
    localparam logic [15:0] EXPIRY     = 16'(REALIGN_INTERVAL - 1);
    localparam bit          PERIODIC   = (REALIGN_INTERVAL != 0);

    state_t      state;
    state_t      next_state;
    logic [3:0]  burst_cnt;
    logic [15:0] interval_cnt;
    logic        burst_start;
    logic        burst_last;

    // Align_req is only honoured in DATA, so a request during a burst is dropped.
    always_comb begin
        burst_start = 1'b0;
        if (state == ST_DATA) begin
            burst_start = Align_req || (PERIODIC && (interval_cnt == EXPIRY));
        end
    end

    assign burst_last = (state == ST_BURST) && (burst_cnt == LAST_COMMA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BURST;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_BURST: if (burst_last)  next_state = ST_DATA;
            ST_DATA:  if (burst_start) next_state = ST_BURST;
            default:                   next_state = ST_BURST;
        endcase
    end

    always_comb begin
        TxReady = (state == ST_DATA) && !burst_start;
    end

    // The burst-start cycle still emits filler; commas begin once in BURST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Data_out     <= FILLER_SYM;
            DataK_out    <= 1'b0;
            Comma_active <= 1'b0;
            Burst_done   <= 1'b0;
            burst_cnt    <= 4'd0;
            interval_cnt <= 16'd0;
        end else if (state == ST_BURST) begin
            Data_out     <= K28_5;
            DataK_out    <= 1'b1;
            Comma_active <= 1'b1;
            Burst_done   <= burst_last;
            if (burst_last) begin
                burst_cnt    <= 4'd0;
                interval_cnt <= 16'd0;
            end else begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end else begin
            Comma_active <= 1'b0;
            Burst_done   <= 1'b0;
            burst_cnt    <= 4'd0;
            if (TxValid_in && TxReady) begin
                Data_out  <= TxData_in;
                DataK_out <= TxDataK_in;
            end else begin
                Data_out  <= FILLER_SYM;
                DataK_out <= 1'b0;
            end
            if (interval_cnt != 16'hFFFF) begin
                interval_cnt <= interval_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_comma_insertion.sv
// tb/tb_comma_insertion.sv - directed self-checking bench for comma_insertion
module tb_comma_insertion;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_k;
    logic       tx_valid;
    logic       align_req;

    logic       d_ready, d_k, d_ca, d_done;
    logic [7:0] d_data;
    logic       r_ready, r_k, r_ca, r_done;
    logic [7:0] r_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    comma_insertion u_dut (
        .clk(clk), .rst_n(rst_n),
        .TxData_in(tx_data), .TxDataK_in(tx_k), .TxValid_in(tx_valid), .Align_req(align_req),
        .TxReady(d_ready), .Data_out(d_data), .DataK_out(d_k),
        .Comma_active(d_ca), .Burst_done(d_done)
    );

    comma_insertion #(.COMMA_COUNT(3), .REALIGN_INTERVAL(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .TxData_in(tx_data), .TxDataK_in(tx_k), .TxValid_in(tx_valid), .Align_req(align_req),
        .TxReady(r_ready), .Data_out(r_data), .DataK_out(r_k),
        .Comma_active(r_ca), .Burst_done(r_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {Data_out, DataK_out, Comma_active, Burst_done}
    task automatic chk_d(input string tag, input logic [7:0] d, input logic k, input logic ca, input logic dn);
        chk(tag, {21'd0, d_data, d_k, d_ca, d_done}, {21'd0, d, k, ca, dn});
    endtask

    task automatic chk_r(input string tag, input logic [7:0] d, input logic k, input logic ca, input logic dn);
        chk(tag, {21'd0, r_data, r_k, r_ca, r_done}, {21'd0, d, k, ca, dn});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] e_data [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'h06};
    logic [2:0] e_ctl  [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b110, 3'b111, 3'b000};
    logic       e_rdy  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [7:0] d;
        logic       rdy;

        rst_n = 1'b0; tx_data = 8'h00; tx_k = 1'b0; tx_valid = 1'b0; align_req = 1'b0;
        #12;
        chk_d("rst_out_def", 8'h00, 1'b0, 1'b0, 1'b0);
        chk_r("rst_out_i8", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst_ready", {d_ready, r_ready}, 2'b00);
        #1 rst_n = 1'b1;

        // Reset release: three commas, done on the third, then ready.
        for (int i = 1; i <= 3; i++) begin
            tx_valid = 1'b1; tx_data = 8'hEE;
            #1 chk($sformatf("boot_ready_c%0d", i), d_ready, 1'b0);
            tick();
            chk_d($sformatf("boot_comma_c%0d", i), 8'hBC, 1'b1, 1'b1, (i == 3));
            chk_r($sformatf("boot_comma_i8_c%0d", i), 8'hBC, 1'b1, 1'b1, (i == 3));
        end

        // Data transfer, one-cycle latency.
        tx_data = 8'h5A;
        #1 chk("ready_after_boot", {d_ready, r_ready}, 2'b11);
        tick();
        chk_d("data_5a", 8'h5A, 1'b0, 1'b0, 1'b0);
        chk_r("data_5a_i8", 8'h5A, 1'b0, 1'b0, 1'b0);
        tx_data = 8'h3C;
        tick();
        chk_d("data_3c", 8'h3C, 1'b0, 1'b0, 1'b0);
        chk_r("data_3c_i8", 8'h3C, 1'b0, 1'b0, 1'b0);

        // Continuous valid into interval expiry; source advances only on transfer.
        d = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tx_data = d;
            #1 rdy = r_ready;
            chk($sformatf("intv_ready_%0d", i), rdy, e_rdy[i]);
            tick();
            chk_r($sformatf("intv_out_%0d", i), e_data[i], e_ctl[i][2], e_ctl[i][1], e_ctl[i][0]);
            if (rdy) d = d + 8'd1;
        end

        // Align_req pulse in DATA, second pulse during the burst is ignored.
        tx_valid = 1'b0;
        align_req = 1'b1;
        #1 chk("align_ready_low", r_ready, 1'b0);
        tick();
        chk_r("align_filler", 8'h00, 1'b0, 1'b0, 1'b0);
        align_req = 1'b0;
        tick();
        chk_r("align_c1", 8'hBC, 1'b1, 1'b1, 1'b0);
        align_req = 1'b1;
        #1 chk("align_in_burst_ready", r_ready, 1'b0);
        tick();
        chk_r("align_c2", 8'hBC, 1'b1, 1'b1, 1'b0);
        align_req = 1'b0;
        tick();
        chk_r("align_c3", 8'hBC, 1'b1, 1'b1, 1'b1);
        #1 chk("align_ready_after", r_ready, 1'b1);
        tick();
        chk_r("align_post1", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_r("align_post2", 8'h00, 1'b0, 1'b0, 1'b0);

        // Align_req coincident with interval expiry: one burst only.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_r($sformatf("pre_expiry_%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
        end
        align_req = 1'b1;
        #1 chk("coinc_ready_low", r_ready, 1'b0);
        tick();
        chk_r("coinc_filler", 8'h00, 1'b0, 1'b0, 1'b0);
        align_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk_r($sformatf("coinc_c%0d", i), 8'hBC, 1'b1, 1'b1, (i == 3));
        end
        tick();
        chk_r("coinc_post1", 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_r("coinc_post2", 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset after the second comma of a burst.
        align_req = 1'b1;
        tick();
        align_req = 1'b0;
        tick();
        chk_r("pre_rst_c1", 8'hBC, 1'b1, 1'b1, 1'b0);
        tick();
        chk_r("pre_rst_c2", 8'hBC, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_r("midrst_out", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("midrst_ready", {d_ready, r_ready}, 2'b00);
        tick();
        chk_r("midrst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h77;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("rerst_ready_c%0d", i), r_ready, 1'b0);
            tick();
            chk_r($sformatf("rerst_c%0d", i), 8'hBC, 1'b1, 1'b1, (i == 3));
            chk_d($sformatf("rerst_def_c%0d", i), 8'hBC, 1'b1, 1'b1, (i == 3));
        end
        #1 chk("rerst_ready_after", r_ready, 1'b1);
        tick();
        chk_r("rerst_data", 8'h77, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
